// File: rtl/udma_ext_per_pkg.sv
// Shared types and field positions for the external-peripheral serial shift engine.
package udma_ext_per_pkg;

   localparam int CFG_DIV_LSB       = 0;
   localparam int CFG_DIV_W         = 16;
   localparam int CFG_LEN_LSB       = 16;
   localparam int CFG_LEN_W         = 5;
   localparam int CFG_LSB_FIRST_BIT = 21;
   localparam int CFG_EN_BIT        = 22;
   localparam int CFG_LOOPBACK_BIT  = 23;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SCK_LO = 3'd2,
      ST_SCK_HI = 3'd3,
      ST_PUSH   = 3'd4
   } ext_per_state_e;

   typedef struct packed {
      logic [7:0]           rsvd;
      logic                 loopback;
      logic                 en;
      logic                 lsb_first;
      logic [CFG_LEN_W-1:0] len_m1;
      logic [CFG_DIV_W-1:0] div;
   } ext_per_setup_t;

   // Position in the word of the bit handled while the bit counter holds cnt.
   function automatic logic [CFG_LEN_W-1:0] bit_index(input logic [CFG_LEN_W-1:0] cnt,
                                                      input logic [CFG_LEN_W-1:0] len_m1,
                                                      input logic             lsb_first);
      return lsb_first ? (len_m1 - cnt) : cnt;
   endfunction

endpackage

// File: rtl/udma_ext_per_clkdiv.sv
// Loadable down-counter with terminal-count flag; reloads itself on terminal count while enabled.
module udma_ext_per_clkdiv #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 load_i,
   input  logic                 cnt_en_i,
   input  logic [DIV_WIDTH-1:0] load_val_i,
   output logic                 tc_o
);

   logic [DIV_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH-1:0] cnt_d;

   assign tc_o = (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_en_i) begin
         cnt_d = tc_o ? load_val_i : (cnt_q - 1'b1);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/udma_ext_per_shift_engine.sv
// SPI-mode-0 style serial engine between the TX and RX dual-clock FIFOs of the external peripheral.
// Optional build macro EXT_PER_LOOPBACK_EN adds an sdo->sample loopback selected by setup bit 23.
module udma_ext_per_shift_engine
   import udma_ext_per_pkg::*;
#(
   parameter int DIV_WIDTH = 16
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [31:0] cfg_setup_i,
   output logic        busy_o,
   input  logic        tx_valid_i,
   output logic        tx_ready_o,
   input  logic [31:0] tx_data_i,
   output logic        rx_valid_o,
   input  logic        rx_ready_i,
   output logic [31:0] rx_data_o,
   output logic        per_sck_o,
   output logic        per_csn_o,
   output logic        per_sdo_o,
   input  logic        per_sdi_i
);

   ext_per_setup_t setup;
   assign setup = ext_per_setup_t'(cfg_setup_i);

   ext_per_state_e         state_q, state_d;
   logic                   tx_ready_q, tx_ready_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   busy_q, busy_d;
   logic                   sck_q, sck_d;
   logic                   csn_q, csn_d;
   logic                   sdo_q, sdo_d;
   logic [31:0]            data_q, data_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic [CFG_LEN_W-1:0]   len_m1_q, len_m1_d;
   logic                   lsb_q, lsb_d;
   logic [CFG_LEN_W-1:0]   cnt_q, cnt_d;
   logic [31:0]            rx_shift_q, rx_shift_d;
   logic [31:0]            rx_data_q, rx_data_d;
   logic                   sample;
   logic                   div_tc;
   logic                   unused_cfg;

`ifdef EXT_PER_LOOPBACK_EN
   logic lpbk_q, lpbk_d;
   assign sample     = lpbk_q ? sdo_q : per_sdi_i;
   assign unused_cfg = ^setup.rsvd;
`else
   assign sample     = per_sdi_i;
   assign unused_cfg = ^{setup.rsvd, setup.loopback};
`endif

   // The same counter times both sck phases; it is primed in LOAD and reloads on every terminal count.
   udma_ext_per_clkdiv #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_clkdiv (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .load_i     (state_q == ST_LOAD),
      .cnt_en_i   ((state_q == ST_SCK_LO) || (state_q == ST_SCK_HI)),
      .load_val_i (div_q),
      .tc_o       (div_tc)
   );

   always_comb begin
      state_d    = state_q;
      sck_d      = sck_q;
      csn_d      = csn_q;
      sdo_d      = sdo_q;
      data_d     = data_q;
      div_d      = div_q;
      len_m1_d   = len_m1_q;
      lsb_d      = lsb_q;
      cnt_d      = cnt_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
`ifdef EXT_PER_LOOPBACK_EN
      lpbk_d     = lpbk_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (tx_valid_i && tx_ready_q) begin
               data_d   = tx_data_i;
               div_d    = DIV_WIDTH'(setup.div);
               len_m1_d = setup.len_m1;
               lsb_d    = setup.lsb_first;
`ifdef EXT_PER_LOOPBACK_EN
               lpbk_d   = setup.loopback;
`endif
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            csn_d      = 1'b0;
            sdo_d      = data_q[bit_index(len_m1_q, len_m1_q, lsb_q)];
            cnt_d      = len_m1_q;
            rx_shift_d = '0;
            state_d    = ST_SCK_LO;
         end
         ST_SCK_LO: begin
            if (div_tc) begin
               sck_d = 1'b1;
               rx_shift_d[bit_index(cnt_q, len_m1_q, lsb_q)] = sample;
               state_d = ST_SCK_HI;
            end
         end
         ST_SCK_HI: begin
            if (div_tc) begin
               sck_d = 1'b0;
               if (cnt_q == '0) begin
                  csn_d     = 1'b1;
                  sdo_d     = 1'b0;
                  rx_data_d = rx_shift_q;
                  state_d   = ST_PUSH;
               end else begin
                  cnt_d   = cnt_q - 1'b1;
                  sdo_d   = data_q[bit_index(cnt_q - 1'b1, len_m1_q, lsb_q)];
                  state_d = ST_SCK_LO;
               end
            end
         end
         ST_PUSH: begin
            if (rx_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Handshake outputs are registered, so they are derived from the next state.
      tx_ready_d = (state_d == ST_IDLE) && setup.en;
      rx_valid_d = (state_d == ST_PUSH);
      busy_d     = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= ST_IDLE;
         tx_ready_q <= 1'b0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         sck_q      <= 1'b0;
         csn_q      <= 1'b1;
         sdo_q      <= 1'b0;
         data_q     <= '0;
         div_q      <= '0;
         len_m1_q   <= '0;
         lsb_q      <= 1'b0;
         cnt_q      <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
`ifdef EXT_PER_LOOPBACK_EN
         lpbk_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tx_ready_q <= tx_ready_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
         sck_q      <= sck_d;
         csn_q      <= csn_d;
         sdo_q      <= sdo_d;
         data_q     <= data_d;
         div_q      <= div_d;
         len_m1_q   <= len_m1_d;
         lsb_q      <= lsb_d;
         cnt_q      <= cnt_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
`ifdef EXT_PER_LOOPBACK_EN
         lpbk_q     <= lpbk_d;
`endif
      end
   end

   assign busy_o     = busy_q;
   assign tx_ready_o = tx_ready_q;
   assign rx_valid_o = rx_valid_q;
   assign rx_data_o  = rx_data_q;
   assign per_sck_o  = sck_q;
   assign per_csn_o  = csn_q;
   assign per_sdo_o  = sdo_q;

endmodule

// File: tb/tb_udma_ext_per_shift_engine.sv
// Directed, table-driven bench for udma_ext_per_shift_engine (expectations depend on EXT_PER_LOOPBACK_EN).
module tb_udma_ext_per_shift_engine;

   logic        clk;
   logic        rstn;
   logic [31:0] cfg;
   logic        busy;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] tx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [31:0] rx_data;
   logic        sck, csn, sdo, sdi;
   logic [1:0]  sdi_mode;   // 0: const 0, 1: const 1, 2: wired to sdo

   int n_chk  = 0;
   int n_pass = 0;

   udma_ext_per_shift_engine #(.DIV_WIDTH(16)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .cfg_setup_i (cfg),
      .busy_o      (busy),
      .tx_valid_i  (tx_valid),
      .tx_ready_o  (tx_ready),
      .tx_data_i   (tx_data),
      .rx_valid_o  (rx_valid),
      .rx_ready_i  (rx_ready),
      .rx_data_o   (rx_data),
      .per_sck_o   (sck),
      .per_csn_o   (csn),
      .per_sdo_o   (sdo),
      .per_sdi_i   (sdi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb sdi = (sdi_mode == 2'd2) ? sdo : sdi_mode[0];

   // Pin monitor: counts sck rising edges, collects sdo at each rise, counts rx_valid cycles.
   int          pulses   = 0;
   int          rxv_seen = 0;
   logic [31:0] cap      = '0;
   logic        sck_prev = 1'b0;
   always @(negedge clk) begin
      if (sck && !sck_prev) begin
         pulses = pulses + 1;
         cap    = {cap[30:0], sdo};
      end
      if (rx_valid) rxv_seen = rxv_seen + 1;
      sck_prev = sck;
   end

   typedef struct {
      logic [15:0] div;
      logic [4:0]  len_m1;
      logic        lsb;
      logic        lpbk;
      logic [1:0]  mode;
      logic [31:0] tx;
      logic [31:0] exp_rx;
      logic [31:0] exp_sdo;
      int          exp_lat;
   } vec_t;

   vec_t vecs[6];

   function automatic logic [31:0] mk_cfg(input logic [15:0] div, input logic [4:0] len_m1,
                                          input logic lsb, input logic en, input logic lpbk);
      return {8'h00, lpbk, en, lsb, len_m1, div};
   endfunction

   function automatic vec_t mk_vec(input logic [15:0] div, input logic [4:0] len_m1, input logic lsb,
                                   input logic lpbk, input logic [1:0] mode, input logic [31:0] tx,
                                   input logic [31:0] exp_rx, input logic [31:0] exp_sdo,
                                   input int exp_lat);
      vec_t v;
      v.div = div; v.len_m1 = len_m1; v.lsb = lsb; v.lpbk = lpbk; v.mode = mode;
      v.tx = tx; v.exp_rx = exp_rx; v.exp_sdo = exp_sdo; v.exp_lat = exp_lat;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   task automatic start_word(input logic [31:0] data, output logic ok);
      int n = 0;
      @(negedge clk);
      tx_data  = data;
      tx_valid = 1'b1;
      while (!tx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = tx_ready;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic wait_rx(output int edges);
      edges = 0;
      while (1) begin
         @(posedge clk);
         #1 edges++;
         if (rx_valid || edges > 3000) break;
      end
   endtask

   task automatic pop_rx();
      @(negedge clk);
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic        ok;
      int          p0, edges;
      logic [31:0] mask;
      cfg      = mk_cfg(v.div, v.len_m1, v.lsb, 1'b1, v.lpbk);
      sdi_mode = v.mode;
      p0       = pulses;
      start_word(v.tx, ok);
      chk($sformatf("v%0d_accept", idx), 32'(ok), 32'd1);
      wait_rx(edges);
      chk($sformatf("v%0d_latency", idx), 32'(edges + 1), 32'(v.exp_lat));
      chk($sformatf("v%0d_rx_data", idx), rx_data, v.exp_rx);
      chk($sformatf("v%0d_sck_pulses", idx), 32'(pulses - p0), 32'(v.len_m1) + 32'd1);
      mask = (v.len_m1 == 5'd31) ? 32'hFFFF_FFFF : ((32'd1 << (32'(v.len_m1) + 1)) - 32'd1);
      chk($sformatf("v%0d_sdo_bits", idx), cap & mask, v.exp_sdo);
      chk($sformatf("v%0d_push_pins", idx), {29'd0, csn, busy, tx_ready}, 32'b110);
      pop_rx();
      chk($sformatf("v%0d_rx_popped", idx), {30'd0, rx_valid, busy}, 32'd0);
   endtask

   initial begin
      logic        ok;
      int          edges, n, bad, p0, r0;
      logic [31:0] lpbk_exp;

`ifdef EXT_PER_LOOPBACK_EN
      lpbk_exp = 32'h0000_1234;
`else
      lpbk_exp = 32'h0000_0000;
`endif
      //               div    len-1  lsb  lpbk mode tx            exp_rx        exp_sdo       lat
      vecs[0] = mk_vec(16'd0, 5'd7,  1'b0, 1'b0, 2'd2, 32'h0000_00A5, 32'h0000_00A5, 32'h0000_00A5, 18);
      vecs[1] = mk_vec(16'd3, 5'd31, 1'b1, 1'b0, 2'd1, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001, 258);
      vecs[2] = mk_vec(16'd1, 5'd15, 1'b0, 1'b1, 2'd0, 32'h0000_1234, lpbk_exp,      32'h0000_1234, 66);
      vecs[3] = mk_vec(16'd0, 5'd3,  1'b1, 1'b0, 2'd2, 32'hFFFF_FFFC, 32'h0000_000C, 32'h0000_0003, 10);
      vecs[4] = mk_vec(16'd2, 5'd0,  1'b0, 1'b0, 2'd1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 8);
      vecs[5] = mk_vec(16'd0, 5'd31, 1'b0, 1'b0, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 66);

      rstn     = 1'b0;
      cfg      = mk_cfg(16'd0, 5'd7, 1'b0, 1'b1, 1'b0);
      tx_valid = 1'b0;
      tx_data  = '0;
      rx_ready = 1'b0;
      sdi_mode = 2'd0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {25'd0, tx_ready, rx_valid, busy, sck, csn, sdo, 1'b0}, 32'b0000_0100);
      chk("reset_rx_data", rx_data, 32'd0);
      rstn = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // rx_ready held low with a second word already queued
      cfg      = mk_cfg(16'd0, 5'd7, 1'b0, 1'b1, 1'b0);
      sdi_mode = 2'd2;
      start_word(32'h0000_003C, ok);
      @(negedge clk);
      tx_data  = 32'h0000_0081;
      tx_valid = 1'b1;
      wait_rx(edges);
      chk("stall_rx_data", rx_data, 32'h0000_003C);
      p0  = pulses;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx_ready || !csn || sck || !rx_valid || !busy || rx_data != 32'h0000_003C) bad++;
      end
      chk("stall_hold_cycles_bad", 32'(bad), 32'd0);
      chk("stall_no_sck", 32'(pulses - p0), 32'd0);
      pop_rx();
      n = 0;
      while (!tx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("stall_second_ready", 32'(tx_ready), 32'd1);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      wait_rx(edges);
      chk("stall_second_latency", 32'(edges + 1), 32'd18);
      chk("stall_second_rx_data", rx_data, 32'h0000_0081);
      pop_rx();

      // en dropped and setup rewritten after the third bit of a 16-bit word
      cfg      = mk_cfg(16'd1, 5'd15, 1'b0, 1'b1, 1'b0);
      sdi_mode = 2'd2;
      p0       = pulses;
      start_word(32'h0000_BEEF, ok);
      n = 0;
      while ((pulses - p0) < 3 && n < 500) begin
         @(negedge clk);
         n++;
      end
      cfg = mk_cfg(16'd5, 5'd3, 1'b1, 1'b0, 1'b1);
      wait_rx(edges);
      chk("en_drop_rx_data", rx_data, 32'h0000_BEEF);
      chk("en_drop_sck_pulses", 32'(pulses - p0), 32'd16);
      chk("en_drop_sdo_bits", cap & 32'h0000_FFFF, 32'h0000_BEEF);
      pop_rx();
      @(negedge clk);
      tx_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx_ready || busy) bad++;
      end
      tx_valid = 1'b0;
      chk("en_drop_no_accept", 32'(bad), 32'd0);

      // asynchronous reset during a high sck phase
      cfg      = mk_cfg(16'd3, 5'd7, 1'b0, 1'b1, 1'b0);
      sdi_mode = 2'd1;
      start_word(32'h0000_00FF, ok);
      n = 0;
      while (!sck && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_reached_sck_hi", 32'(sck), 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk("rst_mid_pins", {28'd0, csn, sck, rx_valid, busy}, 32'b1000);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      r0 = rxv_seen;
      p0 = pulses;
      repeat (100) @(negedge clk);
      chk("rst_mid_no_push", 32'(rxv_seen - r0), 32'd0);
      chk("rst_mid_no_sck", 32'(pulses - p0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
